// File: rtl/imm_pkg.sv
// Shared opcode and immediate-format definitions for the immediate generator.
// Opcodes are the RV32I/RV64I major opcodes found in instruction bits [6:0].
package imm_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SRXI  = 3'b101;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_NONE  = 3'd7
  } fmt_e;

endpackage

// File: rtl/immediate_unit_pipe_if.sv
// Instruction-in / immediate-out handshake bundle of the pipelined immediate unit.
// The slave modport is the unit itself; master is the surrounding pipeline.
interface immediate_unit_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) ();

  logic             valid_i;
  logic             ready_o;
  logic [31:0]      instruction_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  immediate_o;
  fmt_e             fmt_o;
  logic             illegal_o;
  logic [CNT_W-1:0] illegal_cnt_o;

  modport slave (
    input  valid_i, instruction_i, ready_i,
    output ready_o, valid_o, immediate_o, fmt_o, illegal_o, illegal_cnt_o
  );

  modport master (
    output valid_i, instruction_i, ready_i,
    input  ready_o, valid_o, immediate_o, fmt_o, illegal_o, illegal_cnt_o
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word to sign-extended immediate,
// format code and illegal-opcode flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       sign;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign sign   = instr_i[31];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    imm_o     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;

    // Signed formats fill the whole word with the sign first, then overlay the
    // low bits; this works for both XLEN=32 and XLEN=64 without zero-width parts.
    unique case (opcode)
      OP_IMM: begin
        if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
          fmt_o = FMT_SHAMT;
          if (XLEN == 64) imm_o[5:0] = instr_i[25:20];
          else            imm_o[4:0] = instr_i[24:20];
        end else begin
          fmt_o       = FMT_I;
          imm_o       = {XLEN{sign}};
          imm_o[11:0] = instr_i[31:20];
        end
      end
      LOAD, JALR: begin
        fmt_o       = FMT_I;
        imm_o       = {XLEN{sign}};
        imm_o[11:0] = instr_i[31:20];
      end
      STORE: begin
        fmt_o       = FMT_S;
        imm_o       = {XLEN{sign}};
        imm_o[11:0] = {instr_i[31:25], instr_i[11:7]};
      end
      BRANCH: begin
        fmt_o       = FMT_B;
        imm_o       = {XLEN{sign}};
        imm_o[12:0] = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        fmt_o       = FMT_U;
        imm_o       = {XLEN{sign}};
        imm_o[31:0] = {instr_i[31:12], 12'b0};
      end
      JAL: begin
        fmt_o       = FMT_J;
        imm_o       = {XLEN{sign}};
        imm_o[20:0] = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      OP: begin
        fmt_o = FMT_R;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/immediate_unit_pipe.sv
// Pipelined immediate generator: decode feeds an output register backed by a
// one-entry skid register, plus a saturating illegal-opcode counter.
module immediate_unit_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  immediate_unit_pipe_if.slave bus
);

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_ill;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  fmt_e             out_fmt_q,   out_fmt_d;
  logic             out_ill_q,   out_ill_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  fmt_e             skid_fmt_q,   skid_fmt_d;
  logic             skid_ill_q,   skid_ill_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             out_load;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (bus.instruction_i),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_ill)
  );

  // Ready depends only on registered skid state, so ready_i never reaches ready_o.
  assign bus.ready_o = !skid_valid_q && !reset;
  assign accept      = bus.valid_i && bus.ready_o;
  assign out_load    = !out_valid_q || bus.ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    cnt_d        = cnt_q;

    if (out_load) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_ill_d    = skid_ill_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_fmt_d   = dec_fmt;
        out_ill_d   = dec_ill;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // A new accept parks in the skid entry whenever the output slot is taken.
    if (accept && (!out_load || skid_valid_q)) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_ill_d   = dec_ill;
    end

    if (accept && dec_ill && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_NONE;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_ill_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.valid_o       = out_valid_q;
  assign bus.immediate_o   = out_imm_q;
  assign bus.fmt_o         = out_fmt_q;
  assign bus.illegal_o     = out_ill_q;
  assign bus.illegal_cnt_o = cnt_q;

endmodule
